irda_dma_bridge: RTL and testbench

Wishbone master DMA engine sitting directly on the IrDA core's DMA handshake pins. It services `dma_req_t_o` by moving 32-bit words from system memory into the IrDA transmit FIFO register, and `dma_req_r_o` by moving words from the IrDA receive FIFO register into memory. Each completed word is acknowledged with a one-cycle `dma_ack_t_i`/`dma_ack_r_i` pulse. Software programs the base address and word count per channel through the direct configuration inputs; the bridge shares one Wishbone master port for both the memory access and the IrDA register access.

---
 rtl/irda_dma_bridge_if.sv | 25 ++
 rtl/irda_dma_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_irda_dma_bridge.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irda_dma_bridge_if.sv
// Wishbone master bus bundle for the IrDA DMA bridge.
// The bridge takes the master side; memory and IrDA registers sit on the slave side.
interface irda_dma_bridge_if;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_ack_i;
    logic        m_err_i;

    modport master (
        output m_adr_o, m_dat_o, m_sel_o,
        output m_we_o, m_cyc_o, m_stb_o,
        input  m_dat_i, m_ack_i, m_err_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_sel_o,
        input  m_we_o, m_cyc_o, m_stb_o,
        output m_dat_i, m_ack_i, m_err_i
    );
endinterface

// File: rtl/irda_dma_bridge.sv
// Two-channel word DMA between system memory and the IrDA FIFO registers.
// One shared Wishbone master; RX wins arbitration, one word per request.
module irda_dma_bridge #(
    parameter logic [31:0] TX_FIFO_ADR = 32'h0000_0000,
    parameter logic [31:0] RX_FIFO_ADR = 32'h0000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       tx_base_i,
    input  logic [15:0]       tx_len_i,
    input  logic              tx_start_i,
    input  logic [31:0]       rx_base_i,
    input  logic [15:0]       rx_len_i,
    input  logic              rx_start_i,
    input  logic              dma_req_t_i,
    output logic              dma_ack_t_o,
    input  logic              dma_req_r_i,
    output logic              dma_ack_r_o,
    irda_dma_bridge_if.master wb,
    output logic              tx_busy_o,
    output logic              rx_busy_o,
    output logic              tx_done_o,
    output logic              rx_done_o,
    output logic              tx_err_o,
    output logic              rx_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ACK,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    // RD has a data-capture cycle after the read ack: stb low, cyc held
    logic        rdp_q, rdp_d;
    // channel owning the current word: 1 = RX, 0 = TX
    logic        ch_q, ch_d;
    logic [31:0] dat_q, dat_d;

    logic [31:0] tx_adr_q, tx_adr_d, rx_adr_q, rx_adr_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic        tx_busy_q, tx_busy_d, rx_busy_q, rx_busy_d;
    logic        tx_done_q, tx_done_d, rx_done_q, rx_done_d;
    logic        tx_err_q, tx_err_d, rx_err_q, rx_err_d;
    logic        ack_t_q, ack_t_d, ack_r_q, ack_r_d;

    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [31:0] adr_q, adr_d;

    logic        fail;
    logic        word_done;

    // Next-state, channel bookkeeping and registered bus outputs
    always_comb begin
        state_d   = state_q;
        rdp_d     = rdp_q;
        ch_d      = ch_q;
        dat_d     = dat_q;
        tx_adr_d  = tx_adr_q;
        rx_adr_d  = rx_adr_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        tx_busy_d = tx_busy_q;
        rx_busy_d = rx_busy_q;
        tx_err_d  = tx_err_q;
        rx_err_d  = rx_err_q;
        tx_done_d = 1'b0;
        rx_done_d = 1'b0;
        ack_t_d   = 1'b0;
        ack_r_d   = 1'b0;
        fail      = 1'b0;
        word_done = 1'b0;

        // A zero-length start arms nothing and reports done at once
        if (tx_start_i && !tx_busy_q) begin
            tx_adr_d  = tx_base_i;
            tx_cnt_d  = tx_len_i;
            tx_err_d  = 1'b0;
            tx_busy_d = (tx_len_i != 16'd0);
            tx_done_d = (tx_len_i == 16'd0);
        end
        if (rx_start_i && !rx_busy_q) begin
            rx_adr_d  = rx_base_i;
            rx_cnt_d  = rx_len_i;
            rx_err_d  = 1'b0;
            rx_busy_d = (rx_len_i != 16'd0);
            rx_done_d = (rx_len_i == 16'd0);
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_busy_q && dma_req_r_i) begin
                    ch_d    = 1'b1;
                    rdp_d   = 1'b0;
                    state_d = S_RD;
                end else if (tx_busy_q && dma_req_t_i) begin
                    ch_d    = 1'b0;
                    rdp_d   = 1'b0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (rdp_q) begin
                    rdp_d   = 1'b0;
                    state_d = S_WR;
                end else if (wb.m_err_i) begin
                    fail = 1'b1;
                end else if (wb.m_ack_i) begin
                    dat_d = wb.m_dat_i;
                    rdp_d = 1'b1;
                end
            end
            S_WR: begin
                if (wb.m_err_i) begin
                    fail = 1'b1;
                end else if (wb.m_ack_i) begin
                    word_done = 1'b1;
                    state_d   = S_ACK;
                end
            end
            S_ACK:   state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Failed word: pointers stay on it, channel disarmed
        if (fail) begin
            state_d = S_HOLD;
            rdp_d   = 1'b0;
            if (ch_q) begin
                rx_err_d  = 1'b1;
                rx_busy_d = 1'b0;
            end else begin
                tx_err_d  = 1'b1;
                tx_busy_d = 1'b0;
            end
        end

        // Word retired on entry to ACK so ack, done and busy line up
        if (word_done) begin
            if (ch_q) begin
                rx_adr_d = rx_adr_q + 32'd4;
                rx_cnt_d = rx_cnt_q - 16'd1;
                ack_r_d  = 1'b1;
                if (rx_cnt_q == 16'd1) begin
                    rx_busy_d = 1'b0;
                    rx_done_d = 1'b1;
                end
            end else begin
                tx_adr_d = tx_adr_q + 32'd4;
                tx_cnt_d = tx_cnt_q - 16'd1;
                ack_t_d  = 1'b1;
                if (tx_cnt_q == 16'd1) begin
                    tx_busy_d = 1'b0;
                    tx_done_d = 1'b1;
                end
            end
        end

        cyc_d = (state_d == S_RD) || (state_d == S_WR);
        stb_d = ((state_d == S_RD) && !rdp_d) || (state_d == S_WR);
        we_d  = (state_d == S_WR);
        adr_d = adr_q;
        if (state_d == S_RD) begin
            adr_d = ch_d ? RX_FIFO_ADR : tx_adr_q;
        end else if (state_d == S_WR) begin
            adr_d = ch_d ? rx_adr_q : TX_FIFO_ADR;
        end
    end

    // State and output registers; reset releases the bus immediately
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            rdp_q     <= 1'b0;
            ch_q      <= 1'b0;
            dat_q     <= 32'd0;
            tx_adr_q  <= 32'd0;
            rx_adr_q  <= 32'd0;
            tx_cnt_q  <= 16'd0;
            rx_cnt_q  <= 16'd0;
            tx_busy_q <= 1'b0;
            rx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
            rx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
            rx_err_q  <= 1'b0;
            ack_t_q   <= 1'b0;
            ack_r_q   <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            rdp_q     <= rdp_d;
            ch_q      <= ch_d;
            dat_q     <= dat_d;
            tx_adr_q  <= tx_adr_d;
            rx_adr_q  <= rx_adr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_busy_q <= tx_busy_d;
            rx_busy_q <= rx_busy_d;
            tx_done_q <= tx_done_d;
            rx_done_q <= rx_done_d;
            tx_err_q  <= tx_err_d;
            rx_err_q  <= rx_err_d;
            ack_t_q   <= ack_t_d;
            ack_r_q   <= ack_r_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
        end
    end

    assign wb.m_adr_o  = adr_q;
    assign wb.m_dat_o  = dat_q;
    assign wb.m_sel_o  = 4'hF;
    assign wb.m_we_o   = we_q;
    assign wb.m_cyc_o  = cyc_q;
    assign wb.m_stb_o  = stb_q;
    assign dma_ack_t_o = ack_t_q;
    assign dma_ack_r_o = ack_r_q;
    assign tx_busy_o   = tx_busy_q;
    assign rx_busy_o   = rx_busy_q;
    assign tx_done_o   = tx_done_q;
    assign rx_done_o   = rx_done_q;
    assign tx_err_o    = tx_err_q;
    assign rx_err_o    = rx_err_q;

endmodule

// File: tb/tb_irda_dma_bridge.sv
// Bench for irda_dma_bridge: memory/FIFO slave model, transaction scoreboard,
// per-cycle bus checks and directed scenarios with literal expectations.
module tb_irda_dma_bridge;

    localparam logic [31:0] TXF = 32'hF000_0000;
    localparam logic [31:0] RXF = 32'hF000_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tx_base = 32'd0, rx_base = 32'd0;
    logic [15:0] tx_len = 16'd0, rx_len = 16'd0;
    logic        tx_start = 1'b0, rx_start = 1'b0;
    logic        req_t = 1'b0, req_r = 1'b0;
    logic        ack_t, ack_r;
    logic        tx_busy, rx_busy, tx_done, rx_done, tx_err, rx_err;

    irda_dma_bridge_if bus ();

    irda_dma_bridge #(
        .TX_FIFO_ADR(TXF),
        .RX_FIFO_ADR(RXF)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .tx_base_i  (tx_base),
        .tx_len_i   (tx_len),
        .tx_start_i (tx_start),
        .rx_base_i  (rx_base),
        .rx_len_i   (rx_len),
        .rx_start_i (rx_start),
        .dma_req_t_i(req_t),
        .dma_ack_t_o(ack_t),
        .dma_req_r_i(req_r),
        .dma_ack_r_o(ack_r),
        .wb         (bus),
        .tx_busy_o  (tx_busy),
        .rx_busy_o  (rx_busy),
        .tx_done_o  (tx_done),
        .rx_done_o  (rx_done),
        .tx_err_o   (tx_err),
        .rx_err_o   (rx_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    task automatic check(input string nm, input logic [64:0] act,
                         input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- slave: memory + IrDA FIFO registers ----------------
    logic [31:0] mem [0:255];
    logic [31:0] rx_fifo [0:7];
    logic [2:0]  rx_ptr = 3'd0;
    int          wait_n = 0;
    int          wcnt = 0;
    logic        err_inj = 1'b0;
    logic [31:0] tx_got [$];

    always_comb begin
        bus.m_ack_i = bus.m_cyc_o && bus.m_stb_o && (wcnt >= wait_n);
        bus.m_err_i = err_inj && bus.m_cyc_o && bus.m_stb_o &&
                      bus.m_we_o && (bus.m_adr_o == TXF);
        if (bus.m_adr_o == RXF) bus.m_dat_i = rx_fifo[rx_ptr];
        else                    bus.m_dat_i = mem[bus.m_adr_o[9:2]];
    end

    // expected bus transactions {we, adr, dat}, built from word-level rules
    logic [64:0] exp_log [$];

    task automatic exp_tx_word(input logic [31:0] a);
        exp_log.push_back({1'b0, a, mem[a[9:2]]});
        exp_log.push_back({1'b1, TXF, mem[a[9:2]]});
    endtask

    task automatic exp_rx_word(input logic [31:0] a, input logic [31:0] d);
        exp_log.push_back({1'b0, RXF, d});
        exp_log.push_back({1'b1, a, d});
    endtask

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (bus.m_cyc_o && bus.m_stb_o && !bus.m_ack_i && !bus.m_err_i)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
        if (!rst && bus.m_cyc_o && bus.m_stb_o && bus.m_ack_i &&
            !bus.m_err_i) begin
            logic [64:0] got;
            got = {bus.m_we_o, bus.m_adr_o,
                   bus.m_we_o ? bus.m_dat_o : bus.m_dat_i};
            if (exp_log.size() == 0) begin
                check("bus_txn_extra", got, 65'd0);
            end else begin
                check("bus_txn", got, exp_log.pop_front());
            end
            if (bus.m_we_o) begin
                if (bus.m_adr_o == TXF) tx_got.push_back(bus.m_dat_o);
                else mem[bus.m_adr_o[9:2]] <= bus.m_dat_o;
            end else if (bus.m_adr_o == RXF) begin
                rx_ptr <= rx_ptr + 3'd1;
            end
        end
    end

    // ---------------- per-cycle monitor ----------------
    int ack_t_c [$];
    int ack_r_c [$];
    int done_t_c [$];
    int done_r_c [$];

    always @(negedge clk) begin
        if (!rst) begin
            check("bus_inv",
                  {61'd0, bus.m_sel_o == 4'hF, !(ack_t && ack_r),
                   !bus.m_stb_o || bus.m_cyc_o,
                   !bus.m_we_o || bus.m_cyc_o},
                  {61'd0, 4'b1111});
            if (ack_t)   ack_t_c.push_back(cyc_n);
            if (ack_r)   ack_r_c.push_back(cyc_n);
            if (tx_done) done_t_c.push_back(cyc_n);
            if (rx_done) done_r_c.push_back(cyc_n);
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_obs();
        ack_t_c.delete();
        ack_r_c.delete();
        done_t_c.delete();
        done_r_c.delete();
        tx_got.delete();
    endtask

    task automatic pulse_tx(input logic [31:0] b, input logic [15:0] l);
        tx_base  = b;
        tx_len   = l;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic pulse_rx(input logic [31:0] b, input logic [15:0] l);
        rx_base  = b;
        rx_len   = l;
        rx_start = 1'b1;
        @(negedge clk);
        rx_start = 1'b0;
    endtask

    task automatic wait_quiet(input string nm, input int lim);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (!tx_busy && !rx_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({"wait_", nm}, {64'd0, ok}, 65'd1);
        repeat (4) @(negedge clk);
        check({"txn_left_", nm}, exp_log.size(), 65'd0);
        exp_log.delete();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 + i;
        for (int i = 0; i < 8; i++) rx_fifo[i] = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_bus", {bus.m_cyc_o, bus.m_stb_o, bus.m_we_o,
                          bus.m_sel_o}, {58'd0, 7'b000_1111});
        check("rst_adr", bus.m_adr_o, 65'd0);
        check("rst_dat", bus.m_dat_o, 65'd0);
        check("rst_flags", {ack_t, ack_r, tx_busy, rx_busy,
                            tx_done, rx_done, tx_err, rx_err}, 65'd0);
        rst = 1'b0;
        @(negedge clk);

        // TX 3 words from 0x100
        clear_obs();
        mem[64] = 32'hAAAA_0001;
        mem[65] = 32'hBBBB_0002;
        mem[66] = 32'hCCCC_0003;
        exp_tx_word(32'h100);
        exp_tx_word(32'h104);
        exp_tx_word(32'h108);
        req_t = 1'b1;
        pulse_tx(32'h100, 16'd3);
        check("tx_busy_on", tx_busy, 65'd1);
        wait_quiet("tx3", 100);
        repeat (8) @(negedge clk);
        check("tx3_idle_req", bus.m_cyc_o, 65'd0);
        req_t = 1'b0;
        check("tx3_acks", ack_t_c.size(), 65'd3);
        if (ack_t_c.size() == 3) begin
            check("tx3_gap1", ack_t_c[1] - ack_t_c[0], 65'd6);
            check("tx3_gap2", ack_t_c[2] - ack_t_c[1], 65'd6);
            check("tx3_done_n", done_t_c.size(), 65'd1);
            if (done_t_c.size() == 1)
                check("tx3_done_at", done_t_c[0], ack_t_c[2]);
        end
        check("tx3_fifo_n", tx_got.size(), 65'd3);
        if (tx_got.size() == 3) begin
            check("tx3_fifo0", tx_got[0], 65'hAAAA_0001);
            check("tx3_fifo1", tx_got[1], 65'hBBBB_0002);
            check("tx3_fifo2", tx_got[2], 65'hCCCC_0003);
        end
        check("tx3_busy_off", tx_busy, 65'd0);

        // RX 2 words to 0x200, one wait state per access
        clear_obs();
        rx_fifo[0] = 32'h1111_AAAA;
        rx_fifo[1] = 32'h2222_BBBB;
        rx_ptr = 3'd0;
        wait_n = 1;
        exp_rx_word(32'h200, 32'h1111_AAAA);
        exp_rx_word(32'h204, 32'h2222_BBBB);
        req_r = 1'b1;
        pulse_rx(32'h200, 16'd2);
        wait_quiet("rx2", 100);
        req_r = 1'b0;
        wait_n = 0;
        check("rx2_mem0", mem[128], 65'h1111_AAAA);
        check("rx2_mem1", mem[129], 65'h2222_BBBB);
        check("rx2_acks", ack_r_c.size(), 65'd2);
        check("rx2_done_n", done_r_c.size(), 65'd1);

        // both channels, requests together: RX first
        clear_obs();
        rx_fifo[2] = 32'h3333_CCCC;
        mem[192] = 32'h4444_DDDD;
        exp_rx_word(32'h304, 32'h3333_CCCC);
        exp_tx_word(32'h300);
        req_t = 1'b1;
        req_r = 1'b1;
        tx_base  = 32'h300;
        tx_len   = 16'd1;
        rx_base  = 32'h304;
        rx_len   = 16'd1;
        tx_start = 1'b1;
        rx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        rx_start = 1'b0;
        wait_quiet("both", 100);
        req_t = 1'b0;
        req_r = 1'b0;
        check("both_n", {ack_r_c.size(), ack_t_c.size()}, {1'b0, 32'd1, 32'd1});
        if (ack_r_c.size() == 1 && ack_t_c.size() == 1)
            check("both_order", ack_t_c[0] - ack_r_c[0], 65'd6);
        check("both_mem", mem[193], 65'h3333_CCCC);

        // error on the TX FIFO write (ack raised too: error wins)
        clear_obs();
        mem[0] = 32'hEEEE_0000;
        mem[1] = 32'hEEEE_0001;
        exp_log.push_back({1'b0, 32'h0, 32'hEEEE_0000});
        err_inj = 1'b1;
        req_t = 1'b1;
        pulse_tx(32'h0, 16'd2);
        wait_quiet("err", 100);
        req_t = 1'b0;
        err_inj = 1'b0;
        check("err_flag", {tx_err, tx_busy}, 65'b10);
        check("err_noack", ack_t_c.size() + done_t_c.size(), 65'd0);
        check("err_nofifo", tx_got.size(), 65'd0);

        // zero-length start clears err, done next cycle, no bus
        pulse_tx(32'h0, 16'd0);
        check("len0_done", {tx_done, tx_err, tx_busy, bus.m_cyc_o},
              65'b1000);
        @(negedge clk);
        check("len0_pulse", {tx_done, bus.m_cyc_o}, 65'b00);

        // start while busy is ignored
        clear_obs();
        mem[80] = 32'h5050_0000;
        mem[81] = 32'h5050_0004;
        exp_tx_word(32'h140);
        exp_tx_word(32'h144);
        pulse_tx(32'h140, 16'd2);
        repeat (2) @(negedge clk);
        pulse_tx(32'h180, 16'd5);
        check("ign_cyc", bus.m_cyc_o, 65'd0);
        req_t = 1'b1;
        wait_quiet("ign", 100);
        req_t = 1'b0;
        check("ign_acks", ack_t_c.size(), 65'd2);
        check("ign_done", done_t_c.size(), 65'd1);

        // address wraps past 0xFFFF_FFFC
        clear_obs();
        mem[255] = 32'hFACE_00FC;
        mem[0]   = 32'hFACE_0000;
        exp_tx_word(32'hFFFF_FFFC);
        exp_tx_word(32'h0000_0000);
        req_t = 1'b1;
        pulse_tx(32'hFFFF_FFFC, 16'd2);
        wait_quiet("wrap", 100);
        req_t = 1'b0;
        check("wrap_n", tx_got.size(), 65'd2);
        if (tx_got.size() == 2)
            check("wrap_d1", tx_got[1], 65'hFACE_0000);

        // reset in the middle of a stalled RD
        clear_obs();
        wait_n = 50;
        req_r = 1'b1;
        pulse_rx(32'h380, 16'd3);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (bus.m_cyc_o && bus.m_stb_o) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("rd_seen", {64'd0, seen}, 65'd1);
        end
        #2 rst = 1'b1;
        #1;
        check("rst_async", {bus.m_cyc_o, bus.m_stb_o, bus.m_we_o}, 65'd0);
        check("rst_mid_flags", {ack_t, ack_r, tx_busy, rx_busy,
                                tx_done, rx_done, tx_err, rx_err}, 65'd0);
        check("rst_mid_adr", {bus.m_adr_o, bus.m_dat_o}, 65'd0);
        @(negedge clk);
        req_r = 1'b0;
        wait_n = 0;
        rst = 1'b0;
        exp_log.delete();
        repeat (4) @(negedge clk);
        check("post_rst", {bus.m_cyc_o, rx_busy}, 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
